// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module  : alu_exec_unit
// Brief   : Execute-stage ALU with valid/ready handshakes. Defining
//           ALU_M_EXT_EN adds iterative RV-M multiply/divide.
// Rev     : 1.0  initial release
// ============================================================================

module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            opcodeb5,
    input  logic [1:0]      ALU_op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_illegal;

    logic            w_accept;
    logic            w_alt;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_acc_res;
    logic            w_acc_ill;

    // Held off during reset so nothing is accepted before the state is known.
    assign in_ready  = rst_n && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

    assign w_alt     = funct7b5 && opcodeb5;
    assign w_shamt   = src_b[SHW-1:0];
    assign w_acc_ill = (ALU_op == 2'b11);

    always_comb begin
        w_base = '0;
        case (ALU_op)
            2'b00: w_base = src_a + src_b;
            2'b01: w_base = src_a - src_b;
            2'b10: begin
                case (funct3)
                    3'd0: w_base = w_alt ? (src_a - src_b) : (src_a + src_b);
                    3'd1: w_base = src_a << w_shamt;
                    3'd2: w_base = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                    3'd3: w_base = {{(XLEN-1){1'b0}}, (src_a < src_b)};
                    3'd4: w_base = src_a ^ src_b;
                    3'd5: w_base = w_alt ? $unsigned($signed(src_a) >>> w_shamt)
                                         : (src_a >> w_shamt);
                    3'd6: w_base = src_a | src_b;
                    default: w_base = src_a & src_b;
                endcase
            end
            default: w_base = '0;
        endcase
    end

`ifdef ALU_M_EXT_EN
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [SHW-1:0]    r_cnt;
    logic [2:0]        r_f3;
    logic              r_sa;
    logic              r_sb;

    logic              w_mop;
    logic              w_fast;
    logic              w_a_sop;
    logic              w_b_sop;
    logic              w_sa;
    logic              w_sb;
    logic              w_b_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rmd;
    logic [XLEN-1:0]   w_fin;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;

    assign w_mop    = (ALU_op == 2'b10) && funct7b0 && opcodeb5;
    assign w_a_sop  = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign w_b_sop  = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign w_sa     = w_a_sop && src_a[XLEN-1];
    assign w_sb     = w_b_sop && src_b[XLEN-1];
    assign w_mag_a  = w_sa ? -src_a : src_a;
    assign w_mag_b  = w_sb ? -src_b : src_b;

    assign w_b_zero = (src_b == '0);
    assign w_ovf    = funct3[2] && !funct3[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    assign w_fast   = w_mop && funct3[2] && (w_b_zero || w_ovf);

    always_comb begin
        w_fast_res = '0;
        if (w_b_zero)
            w_fast_res = funct3[1] ? src_a : '1;
        else
            w_fast_res = funct3[1] ? '0 : src_a;
    end

    // Both algorithms share r_acc: {partial/remainder, multiplier/quotient}.
    assign w_hi     = r_acc[2*XLEN-1:XLEN];
    assign w_lo     = r_acc[XLEN-1:0];
    assign w_sum    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_rem_sh = {w_hi, w_lo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_opnd};

    always_comb begin
        w_step = '0;
        if (r_f3[2])
            w_step = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], w_lo[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
        else
            w_step = {w_sum, w_lo[XLEN-1:1]};
    end

    assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo  = (r_sa ^ r_sb) ? -w_lo : w_lo;
    assign w_rmd  = r_sa ? -w_hi : w_hi;

    always_comb begin
        w_fin = '0;
        if (r_f3[2])
            w_fin = r_f3[1] ? w_rmd : w_quo;
        else
            w_fin = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    assign w_acc_res = w_fast ? w_fast_res : w_base;
`else
    logic w_unused_f7b0;

    assign w_unused_f7b0 = funct7b0;
    assign w_acc_res     = w_base;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_M_EXT_EN
            r_acc     <= '0;
            r_opnd    <= '0;
            r_cnt     <= '0;
            r_f3      <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
`endif
        end else if (w_accept) begin
`ifdef ALU_M_EXT_EN
            if (w_mop && !w_fast) begin
                r_state <= S_ITER;
                r_cnt   <= SHW'(XLEN - 1);
                r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                r_opnd  <= w_mag_b;
                r_f3    <= funct3;
                r_sa    <= w_sa;
                r_sb    <= w_sb;
            end else
`endif
            begin
                r_state   <= S_DONE;
                r_result  <= w_acc_res;
                r_zero    <= (w_acc_res == '0);
                r_illegal <= w_acc_ill;
            end
        end else begin
            case (r_state)
`ifdef ALU_M_EXT_EN
                S_ITER: begin
                    r_acc <= w_step;
                    if (r_cnt == '0)
                        r_state <= S_FIN;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                S_FIN: begin
                    r_state   <= S_DONE;
                    r_result  <= w_fin;
                    r_zero    <= (w_fin == '0);
                    r_illegal <= 1'b0;
                end
`endif
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_exec_unit
// Brief   : Directed scoreboard bench for alu_exec_unit (XLEN=32).
// Rev     : 1.0  initial release
// ============================================================================

module tb_alu_exec_unit;

    localparam int XLEN = 32;
    localparam logic [1:0] OPF = 2'b10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            opcodeb5 = 1'b0;
    logic [1:0]      alu_op = 2'b00;
    logic [2:0]      funct3 = 3'd0;
    logic            funct7b5 = 1'b0;
    logic            funct7b0 = 1'b0;
    logic [XLEN-1:0] src_a = '0;
    logic [XLEN-1:0] src_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int nsend  = 0;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          due;
        bit          chk;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcodeb5 (opcodeb5),
        .ALU_op   (alu_op),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .funct7b0 (funct7b0),
        .src_a    (src_a),
        .src_b    (src_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Retirement monitor: pops the scoreboard whenever a result is handed off.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_result: observed=%h expected=none", result);
            end
            if (sb.size() != 0) begin
                m_e = sb.pop_front();
                check($sformatf("result#%0d", m_e.id), result, m_e.res);
                check1($sformatf("zero#%0d", m_e.id), zero, (m_e.res == 32'd0));
                check1($sformatf("illegal#%0d", m_e.id), illegal, m_e.ill);
                if (m_e.chk)
                    check($sformatf("latency#%0d", m_e.id), cycle, m_e.due);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7b5,
                        input logic f7b0, input logic op5, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic ill,
                        input int lat, input bit chk);
        int   t = 0;
        exp_t e;
        alu_op   = op;
        funct3   = f3;
        funct7b5 = f7b5;
        funct7b0 = f7b0;
        opcodeb5 = op5;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check1("accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        nsend++;
        e.res = exp;
        e.ill = ill;
        e.due = cycle + lat;
        e.chk = chk;
        e.id  = nsend;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        src_a    = 32'hDEAD_BEEF;
        src_b    = 32'h0BAD_F00D;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            #3;
            t++;
        end
        check("drain", sb.size(), 32'd0);
    endtask

    task automatic hold_check(input logic [31:0] exp);
        int t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check1("bp_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_result%0d", i), result, exp);
            check1($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
            check1($sformatf("bp_zero%0d", i), zero, (exp == 32'd0));
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'd0);
        check1("rst_zero", zero, 1'b0);
        check1("rst_illegal", illegal, 1'b0);
        check1("rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        check1("in_ready_after_reset", in_ready, 1'b1);
        @(negedge clk);

        send(OPF, 3'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, 1'b1);
        send(OPF, 3'd5, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 0, 1'b1);
        send(OPF, 3'd3, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b1);

        check1("b2b_ready0", in_ready, 1'b1);
        send(OPF, 3'd7, 1'b0, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 0, 1'b1);
        check1("b2b_ready1", in_ready, 1'b1);
        send(OPF, 3'd1, 1'b0, 1'b0, 1'b1, 32'd1, 32'd35, 32'd8, 1'b0, 0, 1'b1);
        check1("b2b_ready2", in_ready, 1'b1);
        send(OPF, 3'd4, 1'b0, 1'b0, 1'b1, 32'd5, 32'd5, 32'd0, 1'b0, 0, 1'b1);

        send(2'b00, 3'd5, 1'b1, 1'b1, 1'b1, 32'd7, 32'd9, 32'd16, 1'b0, 0, 1'b1);
        send(2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 0, 1'b1);
        send(OPF, 3'd2, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0, 1'b1);
        send(OPF, 3'd5, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 0, 1'b1);
        send(OPF, 3'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 0, 1'b1);
        send(OPF, 3'd6, 1'b0, 1'b0, 1'b1, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 0, 1'b1);
        send(2'b11, 3'd0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 1'b1, 0, 1'b1);
        wait_drain();

`ifdef ALU_M_EXT_EN
        send(OPF, 3'd1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, XLEN + 1, 1'b1);
        send(OPF, 3'd3, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, XLEN + 1, 1'b1);
        send(OPF, 3'd2, 1'b0, 1'b1, 1'b1, 32'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, XLEN + 1, 1'b1);
        send(OPF, 3'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, XLEN + 1, 1'b1);
        send(OPF, 3'd5, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);
        send(OPF, 3'd7, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, 0, 1'b1);
        send(OPF, 3'd6, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 1'b1);
        send(OPF, 3'd4, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0, 1'b1);
        send(OPF, 3'd4, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, XLEN + 1, 1'b1);
        send(OPF, 3'd6, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, XLEN + 1, 1'b1);
        send(OPF, 3'd5, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, XLEN + 1, 1'b1);
        send(OPF, 3'd7, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd2, 1'b0, XLEN + 1, 1'b1);
        wait_drain();

        out_ready = 1'b0;
        send(OPF, 3'd0, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, 0, 1'b0);
        hold_check(32'd42);
        out_ready = 1'b1;
        wait_drain();

        // Abort a multiply partway through its iterations.
        send(OPF, 3'd0, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, XLEN + 1, 1'b1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check1("iter_rst_out_valid", out_valid, 1'b0);
        check1("iter_rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check1("iter_rel_in_ready", in_ready, 1'b1);
        send(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 0, 1'b1);
        wait_drain();
`else
        send(OPF, 3'd0, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 32'd13, 1'b0, 0, 1'b1);
        send(OPF, 3'd0, 1'b1, 1'b1, 1'b1, 32'd6, 32'd7, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);
        send(OPF, 3'd5, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, 0, 1'b1);
        send(OPF, 3'd3, 1'b0, 1'b1, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b1);
        wait_drain();

        out_ready = 1'b0;
        send(OPF, 3'd0, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 32'd13, 1'b0, 0, 1'b0);
        hold_check(32'd13);
        out_ready = 1'b1;
        wait_drain();
`endif

        // Reset while a result is waiting for the consumer.
        out_ready = 1'b0;
        send(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 0, 1'b0);
        check1("done_pending_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check1("done_rst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check1("done_rel_out_valid", out_valid, 1'b0);
        send(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 0, 1'b1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU decoder: decodes ALU_op/funct3/funct7 and executes the operation in one block.
- Adds RV-M multiply/divide as iterative multi-cycle operations, with valid/ready handshakes on both sides.
- Sits in the execute stage of the multicycle core, between the main decoder/register read and writeback.

Parameters:
XLEN, 32, operand/result width; legal values 32 and 64.
SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented
in_ready  output  1  unit can accept an operation
opcodeb5  input  1  bit 5 of the opcode (R-type = 1)
ALU_op  input  2  00 add, 01 sub, 10 funct-decoded, 11 illegal
funct3  input  3  instruction funct3
funct7b5  input  1  funct7 bit 5 (sub/sra)
funct7b0  input  1  funct7 bit 0 (M-extension select)
src_a  input  XLEN  operand A
src_b  input  XLEN  operand B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  XLEN  operation result
zero  output  1  result == 0
illegal  output  1  ALU_op == 11, qualified by out_valid

Behaviour:
- Reset: asynchronous and active-low. While rst_n = 0, outputs are: state IDLE, out_valid 0, result 0, zero 0 (result-derived, registered), illegal 0, in_ready 0. in_ready is 1 in the first cycle after rst_n deasserts.
- States:
  - IDLE: in_ready = 1.
  - ITER: in_ready = 0.
  - DONE: out_valid = 1.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. Inputs are captured on that edge; later input changes are ignored.
- Back-to-back: in_ready = (state == IDLE) || (state == DONE && out_ready). Retiring a result and accepting a new operation in the same cycle is allowed.
- Base decode: ALU_op 10 with (funct7b0 && opcodeb5) == 0 decodes:
  - add/sub: sub when funct7b5 && opcodeb5.
  - sll, slt, sltu, xor, or, and.
  - srl/sra: sra when funct7b5 && opcodeb5.
  - Shift amount is src_b[SHW-1:0]. sra sign-fills from src_a[XLEN-1].
- Base latency: accept edge N, DONE with result valid after edge N (one cycle).
- ALU_op 11: result 0, illegal 1, same one-cycle latency. Never hangs.
- M ops: funct7b0 && opcodeb5 && ALU_op == 10, and only when the M-extension macro is defined.
  - funct3 0 mul, 1 mulh, 2 mulhsu, 3 mulhu: XLEN-step shift-add on operand magnitudes into a 2*XLEN register, then a one-cycle sign fix. DONE after edge N+XLEN+1. mul returns the low half; the others return the high half.
  - funct3 4 div, 5 divu, 6 rem, 7 remu: restoring radix-2 on magnitudes, same latency. Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- Divide fast paths, one-cycle latency, ITER skipped:
  - Divisor 0: quotient all-ones; remainder src_a.
  - Signed overflow (src_a = most-negative, src_b = -1): quotient src_a; remainder 0.
- ITER: step counter runs XLEN-1 down to 0, then a finalize cycle, then DONE.
- DONE: result, zero and illegal are held stable while out_ready = 0. On out_ready, go to IDLE, or accept the next operation if in_valid.
- Reset mid-ITER or mid-DONE: operation discarded, no out_valid pulse afterward.

Optional Feature:
- Macro: ALU_M_EXT_EN.
- Defined: M ops behave as above.
- Undefined: funct7b0 is ignored and decode is base-only. mul encodings execute as the base funct3 op (for example funct3 0 is add, or sub when funct7b5 && opcodeb5). ITER state and the shift/divide datapath are not synthesised. All ops complete in one cycle.

Test Plan:
- Base ops, XLEN=32, out_ready held 1:
  - ALU_op 10, funct3 0, funct7b5 1, opcodeb5 1, a 5, b 7 -> result 0xFFFFFFFE, out_valid one cycle after accept.
  - funct3 5, sra, a 0x80000000, b 4 -> result 0xF8000000.
  - funct3 3, sltu, a 1, b 0xFFFFFFFF -> result 1.
- Back-to-back: three ops on consecutive cycles -> three results on consecutive cycles, in_ready never drops.
- Multiply: mulh, a 0xFFFFFFFF, b 2 -> result 0xFFFFFFFF at cycle 33 after accept. mulhu, same operands -> 1. mul, a 6, b 7 -> 42, zero 0.
- Divide edges:
  - divu by 0, a 0x1234 -> result 0xFFFFFFFF at one cycle.
  - rem, a 0x80000000, b 0xFFFFFFFF -> 0, zero 1.
  - div, a -7, b 2 -> 0xFFFFFFFD; rem, same operands -> 0xFFFFFFFF.
- Backpressure and illegal: out_ready 0 for 5 cycles after mul completes -> result stable, in_ready 0. ALU_op 11 -> illegal 1, result 0.
- Reset: rst_n low during ITER step 10 -> out_valid 0 immediately, in_ready 1 the cycle after release, next add(1,1) returns 2.
